cmd_exec: RTL and testbench

- Command executor directly downstream of the command-word producer.
- Accepts 32-bit command words over a valid/ready handshake and decodes them per the command ICD (CMD_ID_BANK, CMD_ID_OUT).
- Applies BANK commands to per-bank 8-bit value registers.
- Applies OUT commands to a 5-bit output select with a timed strobe. Illegal words are counted and flagged.

---
 rtl/cmd_icd_pkg.sv | 39 +++
 rtl/cmd_exec_if.sv | 22 ++
 rtl/cmd_decode.sv | 62 ++++++
 rtl/cmd_exec.sv | 164 ++++++++++++++++
 tb/tb_cmd_exec.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_icd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_icd_pkg
// Shared command-word layout used by the command producer, cmd_exec and
// cmd_decode.
//
// Word layout (32 bits):
//   [31:28] command id (cmd_id_t)
//   BANK : [15:8] value, [3:0] bank enable mask; [27:16] and [7:4] reserved
//   OUT  : [4:0] output select; [27:5] reserved
// -----------------------------------------------------------------------------
package cmd_icd_pkg;

  localparam int CMD_WIDTH      = 32;
  localparam int BANK_VAL_WIDTH = 8;
  localparam int OUT_SEL_WIDTH  = 5;
  localparam int MAX_BANKS      = 4;

  localparam int CMD_ID_MSB   = 31;
  localparam int CMD_ID_LSB   = 28;
  localparam int CMD_ID_WIDTH = CMD_ID_MSB - CMD_ID_LSB + 1;

  localparam int BANK_EN_MSB  = 3;
  localparam int BANK_EN_LSB  = 0;
  localparam int BANK_VAL_MSB = 15;
  localparam int BANK_VAL_LSB = 8;

  localparam int OUT_SEL_MSB  = 4;
  localparam int OUT_SEL_LSB  = 0;

  // Reserved-bit masks per command class.
  localparam logic [CMD_WIDTH-1:0] BANK_RSVD_MASK = 32'h0FFF_00F0;
  localparam logic [CMD_WIDTH-1:0] OUT_RSVD_MASK  = 32'h0FFF_FFE0;

  typedef enum logic [CMD_ID_WIDTH-1:0] {
    CMD_ID_BANK = 4'h0,
    CMD_ID_OUT  = 4'h1
  } cmd_id_t;

endpackage

// File: rtl/cmd_exec_if.sv
// -----------------------------------------------------------------------------
// cmd_exec_if
// Command-word channel into cmd_exec.
//   cmd_valid : producer has a word on cmd_data
//   cmd_data  : 32-bit command word
//   cmd_ready : executor can accept a word
// Handshake: a word transfers on a rising clk edge where cmd_valid && cmd_ready.
// cmd_data is don't-care while cmd_valid is low; cmd_ready never depends
// combinationally on cmd_valid.
// Modports: master (producer), slave (executor).
// -----------------------------------------------------------------------------
interface cmd_exec_if;
  import cmd_icd_pkg::*;

  logic                 cmd_valid;
  logic [CMD_WIDTH-1:0] cmd_data;
  logic                 cmd_ready;

  modport master (output cmd_valid, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);

endinterface

// File: rtl/cmd_decode.sv
// -----------------------------------------------------------------------------
// cmd_decode
// Purely combinational classifier for one captured command word.
// Build option: CMD_EXEC_STRICT_RSVD_EN -- when defined, nonzero reserved bits
// make a word illegal; otherwise reserved bits are ignored.
// Ports:
//   word_i       : command word
//   is_bank_o    : legal BANK command
//   is_out_o     : legal OUT command
//   is_illegal_o : neither of the above
//   en_o         : bank enable field
//   val_o        : bank value field
//   out_sel_o    : output select field
// -----------------------------------------------------------------------------
module cmd_decode
  import cmd_icd_pkg::*;
#(
  parameter int NUM_BANKS = MAX_BANKS
) (
  input  logic [CMD_WIDTH-1:0]      word_i,
  output logic                      is_bank_o,
  output logic                      is_out_o,
  output logic                      is_illegal_o,
  output logic [MAX_BANKS-1:0]      en_o,
  output logic [BANK_VAL_WIDTH-1:0] val_o,
  output logic [OUT_SEL_WIDTH-1:0]  out_sel_o
);

  // Enable bits at or above NUM_BANKS address banks that do not exist.
  localparam logic [MAX_BANKS-1:0] LEGAL_EN = MAX_BANKS'((1 << NUM_BANKS) - 1);

  logic [CMD_ID_WIDTH-1:0] id;
  logic                    en_bad;
  logic                    bank_rsvd;
  logic                    out_rsvd;
  logic                    bank_rsvd_ok;
  logic                    out_rsvd_ok;

  assign id        = word_i[CMD_ID_MSB:CMD_ID_LSB];
  assign en_o      = word_i[BANK_EN_MSB:BANK_EN_LSB];
  assign val_o     = word_i[BANK_VAL_MSB:BANK_VAL_LSB];
  assign out_sel_o = word_i[OUT_SEL_MSB:OUT_SEL_LSB];

  assign en_bad    = |(en_o & ~LEGAL_EN);
  assign bank_rsvd = |(word_i & BANK_RSVD_MASK);
  assign out_rsvd  = |(word_i & OUT_RSVD_MASK);

`ifdef CMD_EXEC_STRICT_RSVD_EN
  assign bank_rsvd_ok = !bank_rsvd;
  assign out_rsvd_ok  = !out_rsvd;
`else
  logic unused_rsvd;
  assign unused_rsvd  = bank_rsvd ^ out_rsvd;
  assign bank_rsvd_ok = 1'b1;
  assign out_rsvd_ok  = 1'b1;
`endif

  assign is_bank_o    = (cmd_id_t'(id) == CMD_ID_BANK) && !en_bad && bank_rsvd_ok;
  assign is_out_o     = (cmd_id_t'(id) == CMD_ID_OUT) && out_rsvd_ok;
  assign is_illegal_o = !(is_bank_o || is_out_o);

endmodule

// File: rtl/cmd_exec.sv
// -----------------------------------------------------------------------------
// cmd_exec
// Command executor: accepts command words, applies BANK commands to per-bank
// value registers and OUT commands to a select with a timed strobe; rejected
// words pulse err_stb and bump a saturating counter.
// Build option: CMD_EXEC_STRICT_RSVD_EN (see cmd_decode).
// Parameters: NUM_BANKS (1..4), OUT_HOLD_CYCLES (1..256).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   cmd       : command channel (slave side of cmd_exec_if)
//   bank_val  : bank registers, bank i at [8i+7:8i]
//   bank_upd  : one-cycle pulse per bank written
//   out_sel   : last accepted OUT value
//   out_stb   : high OUT_HOLD_CYCLES cycles per OUT command
//   err_stb   : one-cycle pulse per rejected word
//   err_cnt   : saturating rejected-word count
//   busy      : FSM not idle
//   dbg_state : FSM state (0 IDLE, 1 DECODE, 2 HOLD)
// -----------------------------------------------------------------------------
module cmd_exec
  import cmd_icd_pkg::*;
#(
  parameter int NUM_BANKS       = 4,
  parameter int OUT_HOLD_CYCLES = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  cmd_exec_if.slave                           cmd,
  output logic [BANK_VAL_WIDTH*NUM_BANKS-1:0] bank_val,
  output logic [NUM_BANKS-1:0]                bank_upd,
  output logic [OUT_SEL_WIDTH-1:0]            out_sel,
  output logic                                out_stb,
  output logic                                err_stb,
  output logic [7:0]                          err_cnt,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } exec_state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(OUT_HOLD_CYCLES - 1);

  exec_state_t                                   state_q, state_d;
  logic [CMD_WIDTH-1:0]                          word_q, word_d;
  logic [NUM_BANKS-1:0][BANK_VAL_WIDTH-1:0]      bank_q, bank_d;
  logic [NUM_BANKS-1:0]                          bank_upd_q, bank_upd_d;
  logic [OUT_SEL_WIDTH-1:0]                      out_sel_q, out_sel_d;
  logic                                          out_stb_q, out_stb_d;
  logic [7:0]                                    cnt_q, cnt_d;
  logic                                          err_stb_q, err_stb_d;
  logic [7:0]                                    err_cnt_q, err_cnt_d;

  logic                      dec_is_bank;
  logic                      dec_is_out;
  logic                      dec_is_illegal;
  logic [MAX_BANKS-1:0]      dec_en;
  logic [BANK_VAL_WIDTH-1:0] dec_val;
  logic [OUT_SEL_WIDTH-1:0]  dec_out_sel;
  logic                      ready;

  cmd_decode #(.NUM_BANKS(NUM_BANKS)) u_decode (
    .word_i       (word_q),
    .is_bank_o    (dec_is_bank),
    .is_out_o     (dec_is_out),
    .is_illegal_o (dec_is_illegal),
    .en_o         (dec_en),
    .val_o        (dec_val),
    .out_sel_o    (dec_out_sel)
  );

  // Ready is forced low while rst is asserted, so it rises in the first
  // cycle after release without waiting for a clock edge.
  assign ready         = (state_q == IDLE) && !rst;
  assign cmd.cmd_ready = ready;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bank_d     = bank_q;
    bank_upd_d = '0;
    out_sel_d  = out_sel_q;
    out_stb_d  = out_stb_q;
    cnt_d      = cnt_q;
    err_stb_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && ready) begin
          word_d  = cmd.cmd_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (dec_is_bank) begin
          for (int i = 0; i < NUM_BANKS; i++) begin
            if (dec_en[i]) begin
              bank_d[i]     = dec_val;
              bank_upd_d[i] = 1'b1;
            end
          end
        end else if (dec_is_out) begin
          out_sel_d = dec_out_sel;
          out_stb_d = 1'b1;
          cnt_d     = HOLD_LOAD;
          state_d   = HOLD;
        end else if (dec_is_illegal) begin
          err_stb_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          out_stb_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bank_q     <= '0;
      bank_upd_q <= '0;
      out_sel_q  <= '0;
      out_stb_q  <= 1'b0;
      cnt_q      <= '0;
      err_stb_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bank_q     <= bank_d;
      bank_upd_q <= bank_upd_d;
      out_sel_q  <= out_sel_d;
      out_stb_q  <= out_stb_d;
      cnt_q      <= cnt_d;
      err_stb_q  <= err_stb_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bank_val  = bank_q;
  assign bank_upd  = bank_upd_q;
  assign out_sel   = out_sel_q;
  assign out_stb   = out_stb_q;
  assign err_stb   = err_stb_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cmd_exec.sv
// -----------------------------------------------------------------------------
// tb_cmd_exec
// Bench for cmd_exec: a 4-bank / 8-cycle-hold instance driven from a vector
// table and hand-written sequences with a result scoreboard, plus a
// 2-bank / 3-cycle-hold instance for bank-range and hold-length corners.
// -----------------------------------------------------------------------------
module tb_cmd_exec;

  localparam int         EXP_W     = 51;
  localparam logic [1:0] ST_DECODE = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  cmd_exec_if if4 ();
  cmd_exec_if if2 ();

  logic [31:0] bank_val4;
  logic [3:0]  bank_upd4;
  logic [4:0]  out_sel4;
  logic        out_stb4, err_stb4, busy4;
  logic [7:0]  err_cnt4;
  logic [1:0]  dbg_state4;

  logic [15:0] bank_val2;
  logic [1:0]  bank_upd2;
  logic [4:0]  out_sel2;
  logic        out_stb2, err_stb2, busy2;
  logic [7:0]  err_cnt2;
  logic [1:0]  dbg_state2;

  cmd_exec #(.NUM_BANKS(4), .OUT_HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd(if4),
    .bank_val(bank_val4), .bank_upd(bank_upd4), .out_sel(out_sel4),
    .out_stb(out_stb4), .err_stb(err_stb4), .err_cnt(err_cnt4),
    .busy(busy4), .dbg_state(dbg_state4)
  );

  cmd_exec #(.NUM_BANKS(2), .OUT_HOLD_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .cmd(if2),
    .bank_val(bank_val2), .bank_upd(bank_upd2), .out_sel(out_sel2),
    .out_stb(out_stb2), .err_stb(err_stb2), .err_cnt(err_cnt2),
    .busy(busy2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic [31:0] bank;
    logic [3:0]  upd;
    logic [4:0]  sel;
    logic        stb;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [EXP_W-1:0] pk(input logic [31:0] b, input logic [3:0] u,
                                          input logic [4:0] s, input logic stb,
                                          input logic err, input logic [7:0] c);
    return {b, u, s, stb, err, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Result monitor: the cycle after DECODE carries every registered result.
  initial begin
    logic prev_dec;
    prev_dec = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dec = 1'b0;
      end else begin
        if (prev_dec) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got result 0x%0h with empty queue",
                     pk(bank_val4, bank_upd4, out_sel4, out_stb4, err_stb4, err_cnt4));
          end else begin
            chk("sb_result", pk(bank_val4, bank_upd4, out_sel4, out_stb4, err_stb4, err_cnt4),
                exp_q.pop_front());
          end
        end
        prev_dec = (dbg_state4 == ST_DECODE);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rdy4(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!if4.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if4.cmd_ready) note_fail(name);
  endtask

  task automatic send4(input logic [31:0] w, input logic [EXP_W-1:0] e);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    wait_rdy4("send4_ready");
    if4.cmd_valid = 1'b1;
    if4.cmd_data  = w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if4.cmd_valid = 1'b0;
    if4.cmd_data  = $urandom;
  endtask

  // Sends one word, then counts ready-low and strobe-high cycles until ready.
  task automatic send_meas(input logic [31:0] w, input logic [EXP_W-1:0] e,
                           output int rdy_low, output int stb_hi, output logic fall_ok);
    wait_rdy4("meas_ready");
    if4.cmd_valid = 1'b1;
    if4.cmd_data  = w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if4.cmd_valid = 1'b0;
    if4.cmd_data  = $urandom;
    rdy_low = 0;
    stb_hi  = 0;
    fall_ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (if4.cmd_ready) begin
        fall_ok = !out_stb4;
        break;
      end
      rdy_low++;
      if (out_stb4) stb_hi++;
    end
  endtask

  // dut2 is always idle when this is called; returns in the result cycle.
  task automatic send2(input logic [31:0] w);
    @(negedge clk);
    if2.cmd_valid = 1'b1;
    if2.cmd_data  = w;
    @(posedge clk);
    #1;
    if2.cmd_valid = 1'b0;
    if2.cmd_data  = $urandom;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] e_bank;
    logic [4:0]  e_sel;
    logic [7:0]  e_cnt;
    int          rdy_low, stb_hi, n;
    logic        fall_ok;

    if4.cmd_valid = 1'b0;
    if4.cmd_data  = 32'h0;
    if2.cmd_valid = 1'b0;
    if2.cmd_data  = 32'h0;

    tbl[0] = '{32'h0000_AB05, 32'h00AB_00AB, 4'b0101, 5'h00, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{32'h0000_CD0A, 32'hCDAB_CDAB, 4'b1010, 5'h00, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{32'h2000_0000, 32'hCDAB_CDAB, 4'b0000, 5'h00, 1'b0, 1'b1, 8'd1};
    tbl[3] = '{32'h1000_0013, 32'hCDAB_CDAB, 4'b0000, 5'h13, 1'b1, 1'b0, 8'd1};
    tbl[4] = '{32'h0000_7700, 32'hCDAB_CDAB, 4'b0000, 5'h13, 1'b0, 1'b0, 8'd1};
    tbl[5] = '{32'hF000_00FF, 32'hCDAB_CDAB, 4'b0000, 5'h13, 1'b0, 1'b1, 8'd2};
    tbl[6] = '{32'h1000_0001, 32'hCDAB_CDAB, 4'b0000, 5'h01, 1'b1, 1'b0, 8'd2};
    tbl[7] = '{32'h0000_120F, 32'h1212_1212, 4'b1111, 5'h01, 1'b0, 1'b0, 8'd2};
`ifdef CMD_EXEC_STRICT_RSVD_EN
    tbl[8] = '{32'h0001_0001, 32'h1212_1212, 4'b0000, 5'h01, 1'b0, 1'b1, 8'd3};
    tbl[9] = '{32'h1000_0020, 32'h1212_1212, 4'b0000, 5'h01, 1'b0, 1'b1, 8'd4};
    e_bank = 32'h1212_1212;
    e_sel  = 5'h01;
    e_cnt  = 8'd4;
`else
    tbl[8] = '{32'h0001_0001, 32'h1212_1200, 4'b0001, 5'h01, 1'b0, 1'b0, 8'd2};
    tbl[9] = '{32'h1000_0020, 32'h1212_1200, 4'b0000, 5'h00, 1'b1, 1'b0, 8'd2};
    e_bank = 32'h1212_1200;
    e_sel  = 5'h00;
    e_cnt  = 8'd2;
`endif

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", if4.cmd_ready, 1'b0);
    chk("rst_outputs", {bank_val4, bank_upd4, out_sel4, out_stb4, err_stb4, err_cnt4, busy4}, '0);
    chk("rst_ready2", if2.cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", if4.cmd_ready, 1'b1);
    chk("rel_ready2", if2.cmd_ready, 1'b1);

    // ---- vector table ----
    for (int i = 0; i < 10; i++) begin
      send4(tbl[i].word, pk(tbl[i].bank, tbl[i].upd, tbl[i].sel, tbl[i].stb, tbl[i].err, tbl[i].cnt));
    end

    // ---- OUT timing: strobe length, ready-low length, accept as strobe falls ----
    e_sel = 5'h13;
    send_meas(32'h1000_0013, pk(e_bank, 4'b0000, e_sel, 1'b1, 1'b0, e_cnt), rdy_low, stb_hi, fall_ok);
    chk("out_rdy_low", rdy_low, 9);
    chk("out_stb_len", stb_hi, 8);
    chk("out_ready_at_fall", fall_ok, 1'b1);

    // ---- BANK timing: ready low exactly one cycle ----
    e_bank[7:0] = 8'h34;
    send_meas(32'h0000_3401, pk(e_bank, 4'b0001, e_sel, 1'b0, 1'b0, e_cnt), rdy_low, stb_hi, fall_ok);
    chk("bank_rdy_low", rdy_low, 1);
    chk("bank_no_stb", stb_hi, 0);

    // ---- 260 illegal words: counter saturates, strobe keeps pulsing ----
    for (int k = 0; k < 260; k++) begin
      logic [3:0] id;
      logic [27:0] body;
      id   = 4'($urandom_range(2, 15));
      body = 28'($urandom);
      e_cnt = (e_cnt == 8'hFF) ? 8'hFF : e_cnt + 8'd1;
      send4({id, body}, pk(e_bank, 4'b0000, e_sel, 1'b0, 1'b1, e_cnt));
    end
    repeat (3) @(negedge clk);
    #1;
    chk("err_cnt_sat", err_cnt4, 8'd255);
    chk("sb_drained", exp_q.size(), 0);

    // ---- two-bank instance ----
    send2(32'h0000_5504);
    chk("nb2_rng_err", err_stb2, 1'b1);
    chk("nb2_rng_cnt", err_cnt2, 8'd1);
    chk("nb2_rng_state", {bank_val2, bank_upd2}, 18'h0);
    @(negedge clk);
    #1;
    chk("nb2_err_pulse", err_stb2, 1'b0);
    send2(32'h0000_7700);
    chk("nb2_en0", {bank_upd2, err_stb2, err_cnt2}, {2'b00, 1'b0, 8'd1});
    send2(32'h0000_5503);
    chk("nb2_bank", {bank_val2, bank_upd2}, {16'h5555, 2'b11});
    send2(32'h0000_AA08);
    chk("nb2_en3", {bank_val2, err_stb2, err_cnt2}, {16'h5555, 1'b1, 8'd2});
    send2(32'h1000_0007);
    chk("nb2_out_sel", out_sel2, 5'h07);
    n = out_stb2 ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!out_stb2) break;
      n++;
    end
    chk("nb2_stb_len", n, 3);
    chk("nb2_ready_after", if2.cmd_ready, 1'b1);

    // ---- reset during HOLD cycle 3 ----
    e_sel = 5'h0A;
    send4(32'h1000_000A, pk(e_bank, 4'b0000, e_sel, 1'b1, 1'b0, e_cnt));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("hold3_stb", out_stb4, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_stb", out_stb4, 1'b0);
    chk("abort_state", {bank_val4, out_sel4, err_cnt4, busy4}, '0);
    chk("abort_ready", if4.cmd_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", if4.cmd_ready, 1'b1);
    chk("abort_rel_stb", out_stb4, 1'b0);

    // Captured word must not execute after reset; next word starts clean.
    send4(32'h0000_9901, pk(32'h0000_0099, 4'b0001, 5'h00, 1'b0, 1'b0, 8'd0));
    repeat (3) @(negedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
